// File: rtl/rom_stream_reader_pkg.sv
// Shared types for the ROM stream reader: ROM geometry, sequencer states and the buffered beat.
package rom_stream_reader_pkg;

  localparam int unsigned ROM_ADDR_W = 10;
  localparam int unsigned ROM_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [ROM_DATA_W-1:0] data;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with registered count and full/empty flags.
// Head entry is visible on o_rd_data whenever o_empty is low.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_wr;
  logic             w_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_rd        = i_rd_en & ~r_empty;
  assign w_wr        = i_wr_en & (~r_full | w_rd);
  assign w_count_nxt = r_count + CNT_W'(w_wr) - CNT_W'(w_rd);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_rd) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/rom_stream_reader.sv
// Burst sequencer for a fixed-latency ROM: issues consecutive addresses under FIFO credit,
// tracks reads in flight and presents returned words as a valid/ready stream with a last flag.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = ROM_ADDR_W,
  parameter int unsigned DATA_W     = ROM_DATA_W,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = RD_LAT + 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_rd_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_last
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned BEAT_W = $bits(beat_t);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_load;
  logic              w_issue;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [RD_LAT-1:0] r_infl_vld;
  logic [RD_LAT-1:0] r_infl_last;
  logic [SUM_W-1:0]  w_inflight;
  logic              w_credit_ok;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  beat_t             w_wr_beat;
  beat_t             w_rd_beat;
  logic              w_last_xfer;

  // Reads in flight plus buffered words may never exceed the buffer: the ROM cannot stall.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      w_inflight = w_inflight + SUM_W'(r_infl_vld[i]);
    end
  end

  assign w_credit_ok = ~w_fifo_full &
                       ((SUM_W'(w_fifo_count) + w_inflight) < SUM_W'(FIFO_DEPTH));
  assign w_last_xfer = ~w_fifo_empty & i_m_ready & w_rd_beat.last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            w_load      = 1'b1;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (r_remaining == LEN_W'(1)) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_last_xfer) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Address counter, length counter and the in-flight valid/last shift register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rom_addr  <= '0;
      r_next_addr <= '0;
      r_remaining <= '0;
      r_infl_vld  <= '0;
      r_infl_last <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_load) begin
        r_next_addr <= i_base_addr;
        r_remaining <= i_len;
      end else if (w_issue) begin
        r_rom_addr  <= r_next_addr;
        r_next_addr <= r_next_addr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end
      r_infl_vld[0]  <= w_issue;
      r_infl_last[0] <= w_issue & (r_remaining == LEN_W'(1));
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_infl_vld[i]  <= r_infl_vld[i-1];
        r_infl_last[i] <= r_infl_last[i-1];
      end
    end
  end

  assign w_wr_beat.data = ROM_DATA_W'(i_rom_rd_data);
  assign w_wr_beat.last = r_infl_last[RD_LAT-1];

  sync_fifo_fwft #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (r_infl_vld[RD_LAT-1]),
    .i_wr_data (w_wr_beat),
    .i_rd_en   (i_m_ready),
    .o_rd_data (w_rd_beat),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rom_addr = r_rom_addr;
  assign o_m_valid  = ~w_fifo_empty;
  assign o_m_data   = DATA_W'(w_rd_beat.data);
  assign o_m_last   = w_rd_beat.last & ~w_fifo_empty;

endmodule
